wb_hazard_pipe: RTL

- Parametrised successor to the single-stage writeback decoder.
- Decodes each issued instruction once, then carries its write-back control (RegWrite, A3, WDSel, T_new) through STAGES pipeline slots (slot 0 = E, last slot = W).
- T_new counts down per slot.
- Per cycle it produces the D-stage stall request and rs/rt forwarding selects, and drives W-stage register-file write controls.

---
 rtl/wb_hazard_pipe.sv | 135 +++++++++++++
 1 files changed

// File: rtl/wb_hazard_pipe.sv
// wb_hazard_pipe: decodes each D-stage instruction once, then carries its
// write-back control (RegWrite, A3, WDSel, T_new) through STAGES slots
// (slot 0 = E, slot STAGES-1 = W). Produces the D-stage stall request and
// rs/rt forwarding selects every cycle, and drives the W-stage GRF controls.
// Optional feature macro: WB_HAZARD_STALL_CNT_EN (stall-cycle counter).
module wb_hazard_pipe #(
  parameter int STAGES = 3,
  parameter int TNEW_W = 2,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Instr_D,
  input  logic [4:0]       rs_D,
  input  logic [4:0]       rt_D,
  input  logic [1:0]       Tuse_rs,
  input  logic [1:0]       Tuse_rt,
  input  logic             flush_E,
  output logic             stall_D,
  output logic [2:0]       fwd_rs,
  output logic [2:0]       fwd_rt,
  output logic             RegWrite_W,
  output logic [4:0]       A3_W,
  output logic [1:0]       WDSel_W,
  output logic [31:0]      Instr_W,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [31:0]       instr;
    logic              rw;
    logic [4:0]        a3;
    logic [1:0]        wdsel;
    logic [TNEW_W-1:0] tnew;
  } slot_t;

  slot_t slot_q [STAGES];
  slot_t slot_d [STAGES];
  slot_t dec;

  logic [5:0] op, funct;
  assign op    = Instr_D[31:26];
  assign funct = Instr_D[5:0];

  // Decode the D-stage instruction into its write-back control fields.
  always_comb begin
    dec       = '0;
    dec.instr = Instr_D;
    case (op)
      6'b000000: begin
        if (funct == 6'b100000 || funct == 6'b100010) begin
          dec.rw   = 1'b1;
          dec.a3   = Instr_D[15:11];
          dec.tnew = TNEW_W'(1);
        end
      end
      6'b001101, 6'b001111: begin
        dec.rw   = 1'b1;
        dec.a3   = Instr_D[20:16];
        dec.tnew = TNEW_W'(1);
      end
      6'b100011: begin
        dec.rw    = 1'b1;
        dec.a3    = Instr_D[20:16];
        dec.wdsel = 2'b01;
        dec.tnew  = TNEW_W'(2);
      end
      6'b000011: begin
        dec.rw    = 1'b1;
        dec.a3    = 5'd31;
        dec.wdsel = 2'b10;
      end
      default: ;
    endcase
    // $0 is hardwired; a write to it is not a real producer.
    if (dec.a3 == 5'd0) dec.rw = 1'b0;
  end

  // Hazard check: scan oldest to youngest so the youngest match wins forwarding.
  always_comb begin
    stall_D = 1'b0;
    fwd_rs  = 3'd0;
    fwd_rt  = 3'd0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (slot_q[k].rw && slot_q[k].a3 == rs_D && rs_D != 5'd0) begin
        if (32'(slot_q[k].tnew) > 32'(Tuse_rs)) stall_D = 1'b1;
        fwd_rs = (slot_q[k].tnew == '0) ? 3'(k + 1) : 3'd0;
      end
      if (slot_q[k].rw && slot_q[k].a3 == rt_D && rt_D != 5'd0) begin
        if (32'(slot_q[k].tnew) > 32'(Tuse_rt)) stall_D = 1'b1;
        fwd_rt = (slot_q[k].tnew == '0) ? 3'(k + 1) : 3'd0;
      end
    end
  end

  // Next slot contents: shift down the pipe, T_new counts down to 0.
  always_comb begin
    // Stall and flush both insert exactly one bubble.
    slot_d[0] = (stall_D || flush_E) ? '0 : dec;
    for (int k = 1; k < STAGES; k++) begin
      slot_d[k] = slot_q[k-1];
      if (slot_q[k-1].tnew != '0) slot_d[k].tnew = slot_q[k-1].tnew - TNEW_W'(1);
    end
  end

  // Slot registers; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) slot_q[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) slot_q[k] <= slot_d[k];
    end
  end

  assign RegWrite_W = slot_q[STAGES-1].rw;
  assign A3_W       = slot_q[STAGES-1].a3;
  assign WDSel_W    = slot_q[STAGES-1].wdsel;
  assign Instr_W    = slot_q[STAGES-1].instr;

`ifdef WB_HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_d = stall_D ? cnt_q + CNT_W'(1) : cnt_q;

  // Stall-cycle counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
